// File: rtl/prog_mem_ctrl.sv
// prog_mem_ctrl: writable program store for the TD4 core plus its run controller.
// A loader fills the store while the CPU is held in reset. The controller then
// paces the CPU with a one-cycle clock-enable pulse:
//   - RUN: one pulse every DIV cycles.
//   - STEP: exactly one pulse per request.
// The CPU fetches combinationally through cpu_addr/cpu_data.
module prog_mem_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DIV    = 4
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              ld_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_done,
    input  logic              run_req,
    input  logic              step_req,
    input  logic              halt_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_data,
    output logic              cpu_en,
    output logic              cpu_rst_n,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_STEP = 2'b11
    } state_e;

    localparam int          DEPTH    = 2 ** ADDR_W;
    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    state_e            state_q, state_d;
    logic [15:0]       div_q, div_d;
    logic              cpu_en_q, cpu_en_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              ld_ready_q, ld_ready_d;
    // Set once the STEP state has committed to issuing its pulse, so that the
    // second STEP cycle (the one carrying the pulse) knows to return to IDLE.
    logic              step_fire_q, step_fire_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_en;

    // Next-state, divider, and registered-output logic.
    // Request priority in every state is: ld_start > halt_req > step_req > run_req.
    always_comb begin
        state_d     = state_q;
        div_d       = '0;
        cpu_en_d    = 1'b0;
        step_fire_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ld_start)      state_d = ST_LOAD;
                else if (halt_req) state_d = ST_IDLE;
                else if (step_req) state_d = ST_STEP;
                else if (run_req)  state_d = ST_RUN;
            end
            ST_LOAD: begin
                if (ld_done) state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (ld_start)      state_d = ST_LOAD;
                else if (halt_req) state_d = ST_IDLE;
                else begin
                    div_d    = (div_q == DIV_LAST) ? 16'd0 : div_q + 16'd1;
                    cpu_en_d = (div_q == DIV_LAST);
                end
            end
            ST_STEP: begin
                // First STEP cycle: abort if ld_start or halt_req is present;
                // otherwise arm the pulse.
                // Second STEP cycle (pulse visible): head back to IDLE.
                if (ld_start)         state_d = ST_LOAD;
                else if (step_fire_q) state_d = ST_IDLE;
                else if (halt_req)    state_d = ST_IDLE;
                else begin
                    step_fire_d = 1'b1;
                    cpu_en_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ld_ready_d  = (state_d == ST_LOAD);
        // Hold the CPU in reset through LOAD and for one cycle after it,
        // so that the PC restarts at 0.
        cpu_rst_n_d = !((state_q == ST_LOAD) || (state_d == ST_LOAD));
    end

    // Control registers: state, divider, and the registered outputs.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            cpu_en_q    <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            ld_ready_q  <= 1'b0;
            step_fire_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cpu_en_q    <= cpu_en_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            ld_ready_q  <= ld_ready_d;
            step_fire_q <= step_fire_d;
        end
    end

    assign wr_en = (state_q == ST_LOAD) && ld_valid && ld_ready_q;

    // Program store: cleared by reset, written only by the loader in LOAD.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    assign cpu_data  = (state_q == ST_LOAD) ? '0 : mem_q[cpu_addr];
    assign cpu_en    = cpu_en_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign ld_ready  = ld_ready_q;
    assign state     = state_q;

endmodule
